// File: rtl/ddr_axi_pkg.sv
// rtl/ddr_axi_pkg.sv - shared types and helpers for the stream-to-AXI write path
package ddr_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_e;

    function automatic logic [31:0] beat_bytes(input int unsigned d_level);
        return 32'd1 << d_level;
    endfunction

endpackage

// File: rtl/axi_stream_writer_if.sv
// rtl/axi_stream_writer_if.sv - input stream plus AW/W/B write channels of the writer
interface axi_stream_writer_if #(
    parameter int A_WIDTH = 25,
    parameter int D_WIDTH = 16
);
    logic               s_valid;
    logic               s_ready;
    logic [D_WIDTH-1:0] s_data;
    logic               awvalid;
    logic               awready;
    logic [A_WIDTH-1:0] awaddr;
    logic [7:0]         awlen;
    logic               wvalid;
    logic               wready;
    logic               wlast;
    logic [D_WIDTH-1:0] wdata;
    logic               bvalid;
    logic               bready;

    modport master (
        input  s_valid, s_data, awready, wready, bvalid,
        output s_ready, awvalid, awaddr, awlen, wvalid, wlast, wdata, bready
    );

    modport slave (
        output s_valid, s_data, awready, wready, bvalid,
        input  s_ready, awvalid, awaddr, awlen, wvalid, wlast, wdata, bready
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/axi_stream_writer.sv
// rtl/axi_stream_writer.sv - packs a valid/ready stream into single-outstanding AXI write bursts
module axi_stream_writer #(
    parameter int         A_WIDTH    = 25,
    parameter int         D_WIDTH    = 16,
    parameter int         D_LEVEL    = 1,
    parameter logic [7:0] WBURST_LEN = 8'd7,
    parameter int         FIFO_AW    = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic               flush,
    axi_stream_writer_if.master bus,
    output logic               busy,
    output logic [31:0]        burst_cnt
);
    import ddr_axi_pkg::*;

    localparam logic [31:0]        BURST_BEATS_W = 32'(WBURST_LEN) + 32'd1;
    localparam logic [FIFO_AW:0]   BURST_BEATS   = BURST_BEATS_W[FIFO_AW:0];
    localparam logic [A_WIDTH-1:0] BEAT_BYTES    = A_WIDTH'(beat_bytes(D_LEVEL));

    wr_state_e          state_q, state_d;
    logic [A_WIDTH-1:0] ptr_q, ptr_d, awaddr_q, awaddr_d;
    logic [7:0]         awlen_q, awlen_d, beat_q, beat_d;
    logic [31:0]        burst_cnt_q, burst_cnt_d;
    logic               flush_pend_q, flush_pend_d;

    logic [FIFO_AW:0]   fifo_count, launch_beats;
    logic               fifo_full, fifo_empty, push, pop, launch, has_full_burst;
    logic [D_WIDTH-1:0] fifo_head;

    sync_fifo_fwft #(.DW(D_WIDTH), .AW(FIFO_AW)) u_fifo (
        .clk_i   (aclk),
        .rst_n_i (aresetn),
        .push_i  (push),
        .wdata_i (bus.s_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign push           = bus.s_valid & ~fifo_full;
    assign pop            = bus.wvalid & bus.wready;
    assign has_full_burst = (fifo_count >= BURST_BEATS);
    assign launch         = (state_q == ST_IDLE) && (has_full_burst || (flush_pend_q && !fifo_empty));
    assign launch_beats   = has_full_burst ? BURST_BEATS : fifo_count;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        beat_d       = beat_q;
        burst_cnt_d  = burst_cnt_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            ST_IDLE: begin
                // a coincident start only moves the pointer for the following burst
                if (start) ptr_d = base_addr;
                if (launch) begin
                    awaddr_d = ptr_q;
                    awlen_d  = 8'(launch_beats - (FIFO_AW+1)'(1));
                    state_d  = ST_AW;
                    if (fifo_count <= BURST_BEATS) flush_pend_d = 1'b0;
                end else if (fifo_empty) begin
                    flush_pend_d = 1'b0;
                end
            end
            ST_AW: begin
                if (bus.awready) begin
                    beat_d  = 8'd0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (pop) begin
                    beat_d = beat_q + 8'd1;
                    if (bus.wlast) state_d = ST_B;
                end
            end
            ST_B: begin
                if (bus.bvalid) begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    ptr_d       = ptr_q + BEAT_BYTES * A_WIDTH'({1'b0, awlen_q} + 9'd1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) flush_pend_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            beat_q       <= '0;
            burst_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            beat_q       <= beat_d;
            burst_cnt_q  <= burst_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.s_ready = ~fifo_full;
    assign bus.awvalid = (state_q == ST_AW);
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = awlen_q;
    assign bus.wvalid  = (state_q == ST_W) & ~fifo_empty;
    assign bus.wdata   = fifo_head;
    assign bus.wlast   = (state_q == ST_W) && (beat_q == awlen_q);
    assign bus.bready  = (state_q == ST_B);
    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
    assign burst_cnt   = burst_cnt_q;
endmodule

// File: tb/tb_axi_stream_writer.sv
// tb/tb_axi_stream_writer.sv - directed scoreboard bench for axi_stream_writer
module tb_axi_stream_writer;
    localparam int A_WIDTH = 25;
    localparam int D_WIDTH = 16;

    typedef struct packed {
        logic [A_WIDTH-1:0] addr;
        logic [7:0]         len;
    } aw_t;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic               start = 1'b0;
    logic               flush = 1'b0;
    logic [A_WIDTH-1:0] base_addr = '0;
    logic               busy;
    logic [31:0]        burst_cnt;

    axi_stream_writer_if #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

    axi_stream_writer #(
        .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .D_LEVEL(1), .WBURST_LEN(8'd7), .FIFO_AW(4)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .base_addr (base_addr),
        .flush     (flush),
        .bus       (bus),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail = 0;
    logic [D_WIDTH-1:0] src_q[$];
    logic [D_WIDTH-1:0] exp_w[$];
    aw_t                exp_aw[$];
    logic [D_WIDTH-1:0] mem[int];
    aw_t                cur_aw = '0;
    int                 beat = 0;
    int                 fifo_cnt = 0;
    int                 aw_stall = 0;
    bit                 w_random = 0;
    bit                 start_req = 0;
    bit                 flush_req = 0;
    bit                 b_pending = 0;
    bit                 saw_full = 0;
    bit                 prev_aw_stall = 0;
    bit                 prev_w_stall = 0;
    logic [A_WIDTH-1:0] prev_awaddr = '0;
    logic [7:0]         prev_awlen = '0;
    logic [D_WIDTH-1:0] prev_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [D_WIDTH-1:0] d;
        @(negedge aclk);
        start = start_req;
        start_req = 0;
        flush = flush_req;
        flush_req = 0;
        bus.s_valid = (src_q.size() != 0);
        bus.s_data  = bus.s_valid ? src_q[0] : '0;
        bus.awready = (aw_stall == 0);
        if (aw_stall > 0 && bus.awvalid) aw_stall--;
        bus.wready = w_random ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.bvalid = b_pending;
        #1;
        if (aresetn) begin
            chk("s_ready", bus.s_ready, (fifo_cnt < 16) ? 1'b1 : 1'b0);
            if (fifo_cnt == 16) saw_full = 1;
            if (prev_aw_stall) begin
                chk("aw_hold_valid", bus.awvalid, 1'b1);
                chk("aw_hold_addr", bus.awaddr, prev_awaddr);
                chk("aw_hold_len", bus.awlen, prev_awlen);
            end
            if (prev_w_stall) begin
                chk("w_hold_valid", bus.wvalid, 1'b1);
                chk("w_hold_data", bus.wdata, prev_wdata);
            end
            if (bus.awvalid && bus.awready) begin
                chk("aw_expected", exp_aw.size() > 0, 1'b1);
                if (exp_aw.size() > 0) begin
                    cur_aw = exp_aw.pop_front();
                    chk("awaddr", bus.awaddr, cur_aw.addr);
                    chk("awlen", bus.awlen, cur_aw.len);
                end
                beat = 0;
            end
            if (bus.wvalid && bus.wready) begin
                chk("w_expected", exp_w.size() > 0, 1'b1);
                if (exp_w.size() > 0) begin
                    d = exp_w.pop_front();
                    chk("wdata", bus.wdata, d);
                end
                chk("wlast", bus.wlast, (beat == int'(cur_aw.len)) ? 1'b1 : 1'b0);
                mem[int'(cur_aw.addr + A_WIDTH'(beat * 2))] = bus.wdata;
                beat++;
                fifo_cnt--;
                if (bus.wlast) b_pending = 1;
            end
            if (bus.bvalid && bus.bready) b_pending = 0;
            if (bus.s_valid && bus.s_ready) begin
                exp_w.push_back(src_q.pop_front());
                fifo_cnt++;
            end
            prev_aw_stall = bus.awvalid && !bus.awready;
            prev_awaddr   = bus.awaddr;
            prev_awlen    = bus.awlen;
            prev_w_stall  = bus.wvalid && !bus.wready;
            prev_wdata    = bus.wdata;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy || b_pending || src_q.size() != 0 || exp_w.size() != 0 || exp_aw.size() != 0) && n < 2000);
        chk(tag, n < 2000, 1'b1);
    endtask

    task automatic send_words(input int first, input int num);
        for (int i = 0; i < num; i++) src_q.push_back(D_WIDTH'(first + i));
    endtask

    task automatic expect_aw(input logic [A_WIDTH-1:0] addr, input logic [7:0] len);
        aw_t e;
        e.addr = addr;
        e.len  = len;
        exp_aw.push_back(e);
    endtask

    initial begin
        logic [D_WIDTH-1:0] rd;
        int n;
        bus.s_valid = 0; bus.s_data = '0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        for (int i = 0; i < 3; i++) tick();
        aresetn = 1'b1;
        tick();
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_wvalid", bus.wvalid, 1'b0);
        chk("rst_wlast", bus.wlast, 1'b0);
        chk("rst_bready", bus.bready, 1'b0);
        chk("rst_awaddr", bus.awaddr, 25'd0);
        chk("rst_awlen", bus.awlen, 8'd0);
        chk("rst_burst_cnt", burst_cnt, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_ready", bus.s_ready, 1'b1);

        base_addr = 25'h100;
        start_req = 1;
        tick();
        expect_aw(25'h100, 8'd7);
        expect_aw(25'h110, 8'd7);
        send_words(0, 16);
        wait_idle("stream_idle");
        chk("stream_bursts", burst_cnt, 32'd2);
        for (int i = 0; i < 16; i++) begin
            rd = mem.exists(32'h100 + 2 * i) ? mem[32'h100 + 2 * i] : 'x;
            chk("readback", rd, D_WIDTH'(i));
        end

        send_words(16'hA0, 3);
        for (int i = 0; i < 20; i++) tick();
        chk("partial_no_aw", bus.awvalid, 1'b0);
        expect_aw(25'h120, 8'd2);
        flush_req = 1;
        wait_idle("flush_idle");
        chk("flush_bursts", burst_cnt, 32'd3);
        send_words(16'hB0, 3);
        for (int i = 0; i < 20; i++) tick();
        chk("flush_cleared_busy", busy, 1'b1);
        chk("flush_cleared_no_aw", bus.awvalid, 1'b0);
        expect_aw(25'h126, 8'd2);
        flush_req = 1;
        wait_idle("flush2_idle");
        chk("flush2_bursts", burst_cnt, 32'd4);

        aw_stall = 20;
        w_random = 1;
        saw_full = 0;
        expect_aw(25'h12C, 8'd7);
        expect_aw(25'h13C, 8'd7);
        send_words(16'h300, 16);
        wait_idle("bp_idle");
        chk("bp_saw_full", saw_full, 1'b1);
        chk("bp_bursts", burst_cnt, 32'd6);
        w_random = 0;

        base_addr = 25'h1FF_FFF0;
        start_req = 1;
        tick();
        expect_aw(25'h1FF_FFF0, 8'd7);
        expect_aw(25'h0, 8'd7);
        send_words(16'h400, 16);
        wait_idle("wrap_idle");
        chk("wrap_bursts", burst_cnt, 32'd8);

        base_addr = 25'h200;
        start_req = 1;
        tick();
        expect_aw(25'h200, 8'd7);
        send_words(16'h500, 16);
        n = 0;
        while (!(exp_aw.size() == 0 && beat >= 4) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_beat3", n < 200, 1'b1);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_awvalid", bus.awvalid, 1'b0);
        chk("mid_rst_wvalid", bus.wvalid, 1'b0);
        chk("mid_rst_wlast", bus.wlast, 1'b0);
        chk("mid_rst_bready", bus.bready, 1'b0);
        chk("mid_rst_awaddr", bus.awaddr, 25'd0);
        chk("mid_rst_awlen", bus.awlen, 8'd0);
        chk("mid_rst_burst_cnt", burst_cnt, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        src_q.delete();
        exp_w.delete();
        exp_aw.delete();
        fifo_cnt = 0;
        b_pending = 0;
        prev_aw_stall = 0;
        prev_w_stall = 0;
        for (int i = 0; i < 2; i++) tick();
        aresetn = 1'b1;
        tick();
        chk("post_rst_s_ready", bus.s_ready, 1'b1);
        chk("post_rst_empty", busy, 1'b0);
        base_addr = 25'h300;
        start_req = 1;
        tick();
        expect_aw(25'h300, 8'd7);
        send_words(16'h600, 8);
        wait_idle("post_rst_idle");
        chk("post_rst_bursts", burst_cnt, 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd = mem.exists(32'h300 + 2 * i) ? mem[32'h300 + 2 * i] : 'x;
            chk("post_rst_data", rd, D_WIDTH'(16'h600 + i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_stream_writer.md
# axi_stream_writer

Packs a simple valid/ready data stream into meta-AXI4 write bursts and drives the write channels (AW/W/B) of `ddr_sdram_ctrl`, sitting directly upstream of the controller in place of, or beside, a test master. Incoming words are buffered in a small FIFO. A burst is issued when a full burst is buffered, or on flush. The write address advances linearly from a programmable base. One burst is outstanding at a time.

## Interface
- `A_WIDTH`, 25: meta-AXI4 byte-address width; equals BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1.
- `D_WIDTH`, 16: data width in bits; equals 8<<D_LEVEL.
- `D_LEVEL`, 1: log2 of bytes per beat.
- `WBURST_LEN`, 8'd7: awlen of a full burst, so a full burst is WBURST_LEN+1 beats.
- `FIFO_AW`, 4: log2 of FIFO depth. Must satisfy 2^FIFO_AW ≥ WBURST_LEN+1.
- Ports:
  - `aclk`, in, 1: the only clock.
  - `aresetn`, in, 1: reset, asynchronous, active-low.
  - `start`, in, 1: pulse that loads `base_addr` into the address pointer. Accepted only in IDLE; ignored in any other state.
  - `base_addr`, in, A_WIDTH: start byte address. Must be aligned to 1<<D_LEVEL.
  - `flush`, in, 1: pulse requesting that any partial burst be written out.
  - `s_valid` / `s_ready` / `s_data`: in / out / in; widths 1 / 1 / D_WIDTH; input stream.
  - `awvalid` / `awready` / `awaddr` / `awlen`: out / in / out / out; widths 1 / 1 / A_WIDTH / 8.
  - `wvalid` / `wready` / `wlast` / `wdata`: out / in / out / out; widths 1 / 1 / 1 / D_WIDTH.
  - `bvalid` / `bready`: in / out; widths 1 / 1.
  - `busy`, out, 1: high when not IDLE, or when the FIFO is non-empty.
  - `burst_cnt`, out, 32: number of completed bursts. A burst counts as complete at the B handshake. Wraps at 2^32.

## Operation
- The FIFO is first-word-fall-through. `s_ready` = FIFO not full. A word is pushed on `s_valid & s_ready`.
- Launch condition, evaluated in IDLE:
  - the FIFO count is at least WBURST_LEN+1, or
  - `flush_pend` is set and the FIFO count is greater than 0.
- On launch:
  - latch `awlen` = min(count, WBURST_LEN+1) − 1;
  - latch `awaddr` = the address pointer;
  - go to AW.
- `flush_pend` is set by a `flush` pulse. It clears when a launch in IDLE finds the count at most WBURST_LEN+1 (that launch drains the FIFO). It also clears in IDLE when the count is 0.
- States:
  - IDLE: leave on the launch condition → AW.
  - AW: `awvalid`=1. On `awready` → W, and load the beat counter with 0.
  - W: `wvalid` = FIFO non-empty. `wdata` = FIFO head. `wlast` = (beat counter == latched awlen). On `wvalid & wready`: pop the FIFO and increment the beat counter. On the handshake with `wlast` → B.
  - B: `bready`=1. On `bvalid`: increment `burst_cnt`, advance the pointer by (awlen+1)<<D_LEVEL, then → IDLE.
- Address arithmetic is modulo 2^A_WIDTH: the pointer wraps silently from the top of memory to 0.
- Pushes continue in every state, limited only by FIFO full. A push and a pop in the same cycle leave the count unchanged.
- A `start` pulse in IDLE in the same cycle as a launch:
  - the launch uses the old pointer;
  - the new base is loaded and takes effect from the next burst.

## Timing
- Reset values:
  - `awvalid`, `wvalid`, `wlast`, `bready` = 0;
  - `awaddr` = 0, `awlen` = 0, address pointer = 0;
  - `burst_cnt` = 0, `busy` = 0;
  - `s_ready` = 1 from the first clock edge after release;
  - FIFO empty, `flush_pend` = 0, state = IDLE.
- `aresetn` asserted mid-burst aborts the burst immediately. FIFO contents are discarded and no B handshake is awaited.
- Launch latency: `awvalid` rises on the cycle after the launch condition becomes true in IDLE.
- AW → W: at least 1 cycle after the `awready` handshake. W → B: 1 cycle after the last W handshake. B → IDLE: 1 cycle.
- Outputs are held stable while valid is high and ready is low (AXI rules). `awaddr`/`awlen` do not change between launch and the AW handshake.
- Throughput: with `wready` held at 1 and the FIFO kept full, W carries one beat per cycle.

## Structure
- Package `ddr_axi_pkg` holds:
  - the state enum (IDLE/AW/W/B);
  - a function computing the beat byte-increment from D_LEVEL.
- One sub-module, `sync_fifo_fwft` (parameters DW, AW), providing:
  - count, full, empty;
  - a single clock and the same asynchronous active-low reset.

## Test plan
- Streaming: `base_addr`=0x100, 16 words 0..15, controller model attached. Expect two bursts:
  - AW at 0x100 and at 0x110, both with awlen=7;
  - `wlast` on beats 7 and 15;
  - `burst_cnt`=2.
- Flush: 3 words, then a `flush` pulse. Expect one AW with awlen=2 and `wlast` on the 3rd beat. `flush_pend` is clear afterwards.
- Backpressure: `awready` held low 20 cycles and `wready` toggled randomly while 16 words are sent. Expect:
  - `awaddr`/`awlen`/`wdata` stable while stalled;
  - `s_ready` falls when 16 words are buffered (FIFO_AW=4);
  - no data loss.
- Wrap: `base_addr` = 2^A_WIDTH − 16, then 16 words. Expect the first AW at 2^A_WIDTH − 16 and the second AW at 0x0.
- Reset in W state: `aresetn` pulsed low after beat 3. Expect:
  - all outputs at their reset values on the same edge;
  - an empty FIFO;
  - a new stream afterwards completes correctly.
- Read-back: data from the streaming scenario read back through the controller's read channel matches 0..15.
